// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory bus arbiter.
//   - ARB_AW / ARB_DW : default bus address / data widths
//   - RST_ENA         : level of rst that resets the block
//   - STOP            : level of a stall request that holds the pipeline
//   - arb_state_e     : arbiter FSM state encoding (ARB_IDLE..ARB_IF_DROP)
package mem_bus_arbiter_pkg;

    localparam int unsigned ARB_AW = 32;
    localparam int unsigned ARB_DW = 32;

    localparam logic RST_ENA = 1'b1;
    localparam logic STOP    = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_IF_BUSY  = 2'd1,
        ARB_MEM_BUSY = 2'd2,
        ARB_IF_DROP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch (IF) and
// data access (MEM); MEM wins ties since it holds the older instruction.
// Optional watchdog: define ARB_TIMEOUT_EN to abort a cycle after TIMEOUT
// busy cycles with a bus_err pulse and a zero-data ack to the requester.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   if_req/if_addr                    fetch request (level, held until if_ack)
//   mem_req/we/addr/wdata/sel         data request (level, held until mem_ack)
//   flush                             pipeline redirect; drops pending fetches
//   bus_req/we/addr/wdata/sel         registered bus master outputs
//   bus_ack/bus_rdata                 slave completion pulse and read data
//   if_ack/if_rdata, mem_ack/mem_rdata  completion pulses and held read data
//   stallreq_from_if/_mem             combinational stall requests to ctrl
//   bus_err                           watchdog timeout pulse (0 when disabled)
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned AW      = ARB_AW,
    parameter int unsigned DW      = ARB_DW,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_wdata,
    input  logic [DW/8-1:0] mem_sel,
    input  logic            flush,
    output logic            bus_req,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_sel,
    input  logic            bus_ack,
    input  logic [DW-1:0]   bus_rdata,
    output logic            if_ack,
    output logic [DW-1:0]   if_rdata,
    output logic            mem_ack,
    output logic [DW-1:0]   mem_rdata,
    output logic            stallreq_from_if,
    output logic            stallreq_from_mem,
    output logic            bus_err
);

    arb_state_e state_q, state_d;

    logic            bus_req_q,   bus_req_d;
    logic            bus_we_q,    bus_we_d;
    logic [AW-1:0]   bus_addr_q,  bus_addr_d;
    logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DW/8-1:0] bus_sel_q,   bus_sel_d;
    logic            if_ack_q,    if_ack_d;
    logic [DW-1:0]   if_rdata_q,  if_rdata_d;
    logic            mem_ack_q,   mem_ack_d;
    logic [DW-1:0]   mem_rdata_q, mem_rdata_d;
    logic            bus_err_q,   bus_err_d;

    logic timeout_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Watchdog: cleared on grant, advances on every busy cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ARB_IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENA) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q is 0 in the first busy cycle, so TIMEOUT-1 marks the last one.
    assign timeout_c = (state_q != ARB_IDLE) && !bus_ack
                       && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    // Watchdog compiled out; TIMEOUT kept so both builds share one interface.
    assign timeout_c = (TIMEOUT == 0) && 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst == RST_ENA) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. No grant while an ack is going out: the acked
    // requester still holds its req in that cycle, which also yields the
    // mandatory turnaround cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (!if_ack_q && !mem_ack_q) begin
                    if (mem_req) begin
                        state_d = ARB_MEM_BUSY;
                    end else if (if_req && !flush) begin
                        state_d = ARB_IF_BUSY;
                    end
                end
            end
            ARB_IF_BUSY: begin
                if (bus_ack || timeout_c) begin
                    state_d = ARB_IDLE;
                end else if (flush) begin
                    state_d = ARB_IF_DROP;
                end
            end
            ARB_IF_DROP: begin
                if (bus_ack || timeout_c) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_MEM_BUSY: begin
                if (bus_ack || timeout_c) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Output logic: bus fields latched at grant, acks/rdata at completion.
    always_comb begin
        bus_req_d   = (state_d != ARB_IDLE);
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        if_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_ack_d   = 1'b0;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (state_d == ARB_MEM_BUSY) begin
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_sel_d   = mem_sel;
                end else if (state_d == ARB_IF_BUSY) begin
                    bus_we_d   = 1'b0;
                    bus_addr_d = if_addr;
                    bus_sel_d  = '1;
                end
            end
            ARB_IF_BUSY: begin
                // A flush coinciding with completion discards the word.
                if (bus_ack) begin
                    if (!flush) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus_rdata;
                    end
                end else if (timeout_c) begin
                    bus_err_d = 1'b1;
                    if (!flush) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = '0;
                    end
                end
            end
            ARB_IF_DROP: begin
                if (!bus_ack && timeout_c) begin
                    bus_err_d = 1'b1;
                end
            end
            ARB_MEM_BUSY: begin
                if (bus_ack) begin
                    mem_ack_d = 1'b1;
                    if (!bus_we_q) begin
                        mem_rdata_d = bus_rdata;
                    end
                end else if (timeout_c) begin
                    bus_err_d = 1'b1;
                    mem_ack_d = 1'b1;
                    if (!bus_we_q) begin
                        mem_rdata_d = '0;
                    end
                end
            end
            default: ;
        endcase
        if (state_d == ARB_IDLE) begin
            bus_we_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst == RST_ENA) begin
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            mem_ack_q   <= 1'b0;
            mem_rdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            if_ack_q    <= if_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_ack_q   <= mem_ack_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_sel   = bus_sel_q;
    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign mem_ack   = mem_ack_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_err   = bus_err_q;

    // Stall until the ack pulse; the ack releases the stall in its own cycle.
    assign stallreq_from_if  = (if_req  && !if_ack_q)  ? STOP : ~STOP;
    assign stallreq_from_mem = (mem_req && !mem_ack_q) ? STOP : ~STOP;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for reset abort and the watchdog (ARB_TIMEOUT_EN).
module tb_mem_bus_arbiter;

    localparam int unsigned TB_TIMEOUT = 4;

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_sel;
        logic        flush;
        logic        bus_ack;
        logic [31:0] bus_rdata;
    } in_t;

    typedef struct packed {
        logic        bus_req;
        logic        bus_we;
        logic [31:0] bus_addr;
        logic [31:0] bus_wdata;
        logic [3:0]  bus_sel;
        logic        if_ack;
        logic [31:0] if_rdata;
        logic        mem_ack;
        logic [31:0] mem_rdata;
        logic        stall_if;
        logic        stall_mem;
        logic        bus_err;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic        flush;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stallreq_from_if;
    logic        stallreq_from_mem;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    vec_t vt [42];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk               (clk),
        .rst               (rst),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_sel           (mem_sel),
        .flush             (flush),
        .bus_req           (bus_req),
        .bus_we            (bus_we),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_sel           (bus_sel),
        .bus_ack           (bus_ack),
        .bus_rdata         (bus_rdata),
        .if_ack            (if_ack),
        .if_rdata          (if_rdata),
        .mem_ack           (mem_ack),
        .mem_rdata         (mem_rdata),
        .stallreq_from_if  (stallreq_from_if),
        .stallreq_from_mem (stallreq_from_mem),
        .bus_err           (bus_err)
    );

    function automatic in_t mk_in(logic ir, logic [31:0] ia, logic mr, logic mw,
                                  logic [31:0] ma, logic [31:0] md, logic [3:0] ms,
                                  logic fl, logic ack, logic [31:0] rd);
        in_t r;
        r = '{ir, ia, mr, mw, ma, md, ms, fl, ack, rd};
        return r;
    endfunction

    function automatic out_t mk_out(logic br, logic bw, logic [31:0] ba, logic [31:0] bd,
                                    logic [3:0] bs, logic ia, logic [31:0] ird, logic ma,
                                    logic [31:0] mrd, logic si, logic sm);
        out_t r;
        r = '{br, bw, ba, bd, bs, ia, ird, ma, mrd, si, sm, 1'b0};
        return r;
    endfunction

    function automatic out_t sample();
        out_t r;
        r = '{bus_req, bus_we, bus_addr, bus_wdata, bus_sel, if_ack, if_rdata,
              mem_ack, mem_rdata, stallreq_from_if, stallreq_from_mem, bus_err};
        return r;
    endfunction

    task automatic apply(input in_t v);
        if_req    = v.if_req;
        if_addr   = v.if_addr;
        mem_req   = v.mem_req;
        mem_we    = v.mem_we;
        mem_addr  = v.mem_addr;
        mem_wdata = v.mem_wdata;
        mem_sel   = v.mem_sel;
        flush     = v.flush;
        bus_ack   = v.bus_ack;
        bus_rdata = v.bus_rdata;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive inputs just after the active edge, sample at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] R1 = 32'h3C01_0001;
    localparam logic [31:0] D  = 32'hDEAD_BEEF;
    localparam logic [31:0] R2 = 32'h1111_1111;
    localparam logic [31:0] R3 = 32'h2222_0000;
    localparam logic [31:0] CF = 32'hCAFE_F00D;

    initial begin
        out_t act;
        in_t  idle_in;
        idle_in = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single fetch with a one-cycle slave.
        vt[0]  = '{mk_in(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0)};
        vt[1]  = '{mk_in(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(1, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0, 1, 0)};
        vt[2]  = '{mk_in(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, R1),        mk_out(1, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0, 1, 0)};
        vt[3]  = '{mk_in(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(0, 0, 32'h100, 0, 4'hF, 1, R1, 0, 0, 0, 0)};
        vt[4]  = '{idle_in,                                           mk_out(0, 0, 32'h100, 0, 4'hF, 0, R1, 0, 0, 0, 0)};
        // Simultaneous IF and MEM store: MEM first, IF after turnaround.
        vt[5]  = '{mk_in(1, 32'h104, 1, 1, 32'h200, D, 4'hF, 0, 0, 0), mk_out(0, 0, 32'h100, 0, 4'hF, 0, R1, 0, 0, 1, 1)};
        vt[6]  = '{mk_in(1, 32'h104, 1, 1, 32'h200, D, 4'hF, 0, 0, 0), mk_out(1, 1, 32'h200, D, 4'hF, 0, R1, 0, 0, 1, 1)};
        vt[7]  = '{mk_in(1, 32'h104, 1, 1, 32'h200, D, 4'hF, 0, 1, 32'h55), mk_out(1, 1, 32'h200, D, 4'hF, 0, R1, 0, 0, 1, 1)};
        vt[8]  = '{mk_in(1, 32'h104, 1, 1, 32'h200, D, 4'hF, 0, 0, 0), mk_out(0, 0, 32'h200, D, 4'hF, 0, R1, 1, 0, 1, 0)};
        vt[9]  = '{mk_in(1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(0, 0, 32'h200, D, 4'hF, 0, R1, 0, 0, 1, 0)};
        vt[10] = '{mk_in(1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(1, 0, 32'h104, D, 4'hF, 0, R1, 0, 0, 1, 0)};
        vt[11] = '{mk_in(1, 32'h104, 0, 0, 0, 0, 0, 0, 1, R2),        mk_out(1, 0, 32'h104, D, 4'hF, 0, R1, 0, 0, 1, 0)};
        vt[12] = '{mk_in(1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(0, 0, 32'h104, D, 4'hF, 1, R2, 0, 0, 0, 0)};
        vt[13] = '{idle_in,                                           mk_out(0, 0, 32'h104, D, 4'hF, 0, R2, 0, 0, 0, 0)};
        // Flush during IF_BUSY, slave acks three cycles later, then new fetch 0x180.
        vt[14] = '{mk_in(1, 32'h108, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(0, 0, 32'h104, D, 4'hF, 0, R2, 0, 0, 1, 0)};
        vt[15] = '{mk_in(1, 32'h108, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(1, 0, 32'h108, D, 4'hF, 0, R2, 0, 0, 1, 0)};
        vt[16] = '{mk_in(1, 32'h108, 0, 0, 0, 0, 0, 1, 0, 0),         mk_out(1, 0, 32'h108, D, 4'hF, 0, R2, 0, 0, 1, 0)};
        vt[17] = '{mk_in(1, 32'h180, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(1, 0, 32'h108, D, 4'hF, 0, R2, 0, 0, 1, 0)};
        vt[18] = '{mk_in(1, 32'h180, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(1, 0, 32'h108, D, 4'hF, 0, R2, 0, 0, 1, 0)};
        vt[19] = '{mk_in(1, 32'h180, 0, 0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0), mk_out(1, 0, 32'h108, D, 4'hF, 0, R2, 0, 0, 1, 0)};
        vt[20] = '{mk_in(1, 32'h180, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(0, 0, 32'h108, D, 4'hF, 0, R2, 0, 0, 1, 0)};
        vt[21] = '{mk_in(1, 32'h180, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(1, 0, 32'h180, D, 4'hF, 0, R2, 0, 0, 1, 0)};
        vt[22] = '{mk_in(1, 32'h180, 0, 0, 0, 0, 0, 0, 1, R3),        mk_out(1, 0, 32'h180, D, 4'hF, 0, R2, 0, 0, 1, 0)};
        vt[23] = '{mk_in(1, 32'h180, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(0, 0, 32'h180, D, 4'hF, 1, R3, 0, 0, 0, 0)};
        vt[24] = '{idle_in,                                           mk_out(0, 0, 32'h180, D, 4'hF, 0, R3, 0, 0, 0, 0)};
        // Flush and bus_ack in the same cycle: data discarded, no ack.
        vt[25] = '{mk_in(1, 32'h1C0, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(0, 0, 32'h180, D, 4'hF, 0, R3, 0, 0, 1, 0)};
        vt[26] = '{mk_in(1, 32'h1C0, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(1, 0, 32'h1C0, D, 4'hF, 0, R3, 0, 0, 1, 0)};
        vt[27] = '{mk_in(1, 32'h1C0, 0, 0, 0, 0, 0, 1, 1, 32'h33),    mk_out(1, 0, 32'h1C0, D, 4'hF, 0, R3, 0, 0, 1, 0)};
        vt[28] = '{idle_in,                                           mk_out(0, 0, 32'h1C0, D, 4'hF, 0, R3, 0, 0, 0, 0)};
        // Flush during MEM_BUSY load: ignored, load completes.
        vt[29] = '{mk_in(0, 0, 1, 0, 32'h300, 0, 4'h3, 0, 0, 0),      mk_out(0, 0, 32'h1C0, D, 4'hF, 0, R3, 0, 0, 0, 1)};
        vt[30] = '{mk_in(0, 0, 1, 0, 32'h300, 0, 4'h3, 1, 0, 0),      mk_out(1, 0, 32'h300, 0, 4'h3, 0, R3, 0, 0, 0, 1)};
        vt[31] = '{mk_in(0, 0, 1, 0, 32'h300, 0, 4'h3, 1, 1, CF),     mk_out(1, 0, 32'h300, 0, 4'h3, 0, R3, 0, 0, 0, 1)};
        vt[32] = '{mk_in(0, 0, 1, 0, 32'h300, 0, 4'h3, 0, 0, 0),      mk_out(0, 0, 32'h300, 0, 4'h3, 0, R3, 1, CF, 0, 0)};
        vt[33] = '{idle_in,                                           mk_out(0, 0, 32'h300, 0, 4'h3, 0, R3, 0, CF, 0, 0)};
        // Stray bus_ack while idle is ignored.
        vt[34] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h44),          mk_out(0, 0, 32'h300, 0, 4'h3, 0, R3, 0, CF, 0, 0)};
        vt[35] = '{idle_in,                                           mk_out(0, 0, 32'h300, 0, 4'h3, 0, R3, 0, CF, 0, 0)};
        // Flush in IDLE blocks an IF grant for that cycle.
        vt[36] = '{mk_in(1, 32'h200, 0, 0, 0, 0, 0, 1, 0, 0),         mk_out(0, 0, 32'h300, 0, 4'h3, 0, R3, 0, CF, 1, 0)};
        vt[37] = '{mk_in(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(0, 0, 32'h300, 0, 4'h3, 0, R3, 0, CF, 1, 0)};
        vt[38] = '{mk_in(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(1, 0, 32'h200, 0, 4'hF, 0, R3, 0, CF, 1, 0)};
        vt[39] = '{mk_in(1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 32'h5),     mk_out(1, 0, 32'h200, 0, 4'hF, 0, R3, 0, CF, 1, 0)};
        vt[40] = '{mk_in(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0),         mk_out(0, 0, 32'h200, 0, 4'hF, 1, 32'h5, 0, CF, 0, 0)};
        vt[41] = '{idle_in,                                           mk_out(0, 0, 32'h200, 0, 4'hF, 0, 32'h5, 0, CF, 0, 0)};

        rst = 1'b1;
        apply(idle_in);
        next_cycle();
        @(negedge clk);
        act = sample();
        chk("reset_bus_req", 32'(act.bus_req), 32'd0);
        chk("reset_outputs", 32'(act.if_ack) | 32'(act.mem_ack) | 32'(act.bus_err) | act.if_rdata | act.mem_rdata | act.bus_addr, 32'd0);

        for (int k = 0; k < 42; k++) begin
            next_cycle();
            rst = 1'b0;
            apply(vt[k].i);
            @(negedge clk);
            act = sample();
            total++;
            if (act !== vt[k].o) begin
                bad++;
                $display("FAIL vec%0d: got %h want %h", k, act, vt[k].o);
            end
        end

        // Reset aborts a MEM cycle in flight; stale ack afterwards is ignored.
        next_cycle();
        apply(mk_in(0, 0, 1, 1, 32'h400, 32'h1234, 4'hF, 0, 0, 0));
        @(negedge clk);
        chk("rst_seq_idle", 32'(bus_req), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rst_seq_busy", 32'(bus_req), 32'd1);
        chk("rst_seq_addr", bus_addr, 32'h400);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_seq_pre", 32'(bus_req), 32'd1);
        next_cycle();
        rst = 1'b0;
        apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99));
        @(negedge clk);
        chk("rst_abort_req", 32'(bus_req), 32'd0);
        chk("rst_abort_acks", 32'(if_ack) | 32'(mem_ack) | 32'(bus_err), 32'd0);
        chk("rst_abort_data", if_rdata | mem_rdata | bus_addr | bus_wdata | 32'(bus_sel), 32'd0);
        next_cycle();
        apply(idle_in);
        @(negedge clk);
        chk("stale_ack_ignored", {30'd0, bus_req, mem_ack}, 32'd0);

`ifdef ARB_TIMEOUT_EN
        // Slave never acks: err + ack one cycle after TIMEOUT busy cycles.
        next_cycle();
        apply(mk_in(0, 0, 1, 0, 32'h500, 0, 4'hF, 0, 0, 0));
        @(negedge clk);
        chk("wd_grant_wait", 32'(bus_req), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            @(negedge clk);
            chk("wd_busy", {30'd0, bus_req, bus_err}, 32'd2);
        end
        next_cycle();
        @(negedge clk);
        chk("wd_err", {29'd0, bus_err, mem_ack, bus_req}, 32'd6);
        chk("wd_rdata", mem_rdata, 32'd0);
        next_cycle();
        apply(idle_in);
        @(negedge clk);
        chk("wd_after", {29'd0, bus_err, mem_ack, bus_req}, 32'd0);
`else
        // Without the watchdog a busy state waits indefinitely.
        next_cycle();
        apply(mk_in(0, 0, 1, 0, 32'h500, 0, 4'hF, 0, 0, 0));
        @(negedge clk);
        chk("wait_grant", 32'(bus_req), 32'd0);
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            @(negedge clk);
            chk("wait_busy", {29'd0, bus_req, bus_err, mem_ack}, 32'd4);
        end
        next_cycle();
        apply(mk_in(0, 0, 1, 0, 32'h500, 0, 4'hF, 0, 1, 32'h77));
        @(negedge clk);
        chk("wait_ack_cycle", 32'(bus_req), 32'd1);
        next_cycle();
        apply(mk_in(0, 0, 1, 0, 32'h500, 0, 4'hF, 0, 0, 0));
        @(negedge clk);
        chk("wait_done", {29'd0, bus_req, bus_err, mem_ack}, 32'd1);
        chk("wait_rdata", mem_rdata, 32'h77);
        next_cycle();
        apply(idle_in);
        @(negedge clk);
        chk("wait_idle", {30'd0, bus_req, mem_ack}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
